// File: rtl/if_fetch_queue.sv
// Fetch-to-decode queue: captures {pc, inst} per I-cache response, presents entries in order to ID.
// Latency: 1 cycle from inst_resp to id_valid, with no empty bypass; sustains 1 enq + 1 deq per cycle.
// Backpressure: fq_full (registered-derived) stalls fetch; a mispredict flush empties the queue and drops one stale response.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_in,
    input  logic                     inst_read,
    input  logic                     inst_resp,
    input  logic [31:0]              inst_rdata,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    output logic                     fq_full,
    output logic [$clog2(DEPTH):0]   fq_count,
    output logic                     overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            in_pass;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            enq, deq, ovf_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= PASS;
        else      state <= state_nxt;
    end

    // DROP swallows exactly one response; a flush while dropping keeps the stale response pending.
    always_comb begin
        state_nxt = state;
        case (state)
            PASS:    if (flush && inst_read && !inst_resp) state_nxt = DROP;
            DROP:    if (!flush && inst_resp)              state_nxt = PASS;
            default:                                       state_nxt = PASS;
        endcase
    end

    always_comb begin
        in_pass = (state == PASS);
    end

    assign full     = (count == CW'(DEPTH));
    assign id_valid = (count != '0);
    assign fq_full  = full;
    assign fq_count = count;
    assign id_pc    = mem[rd_ptr].pc;
    assign id_inst  = mem[rd_ptr].inst;

    assign deq     = id_valid && id_ready && !flush;
    assign enq     = inst_resp && !flush && in_pass && (!full || deq);
    assign ovf_hit = inst_resp && in_pass && !flush && full && !deq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow_err <= 1'b0;
        else if (ovf_hit) overflow_err <= 1'b1;
    end

    // Payload storage carries no reset; id_valid qualifies it.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= '{pc: pc_in, inst: inst_rdata};
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        inst_read;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        fq_full;
    logic [2:0]  fq_count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_read(inst_read),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata), .flush(flush),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .fq_full(fq_full), .fq_count(fq_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data);
        pc_in = pc; inst_rdata = data; inst_resp = 1'b1;
        tick();
        inst_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_in = '0; inst_read = 0; inst_resp = 0; inst_rdata = '0; flush = 0; id_ready = 0;
        tick(); tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", id_valid); end
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fq_count); end
        checks++; if (fq_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", fq_full); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", overflow_err); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push(32'h60, 32'h0000_0013);
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h60) begin errors++; $display("FAIL single_pc: got %h exp 00000060", id_pc); end
        checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL single_inst: got %h exp 00000013", id_inst); end
        checks++; if (fq_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", fq_count); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", id_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) push(32'h60 + 32'(4 * i), 32'h1000 + 32'(i));
        checks++; if (fq_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", fq_full); end
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", fq_count); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h60 + 32'(4 * i);
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== 32'h1000 + 32'(i)) begin
                errors++; $display("FAIL fill_order[%0d]: got v=%b pc=%h inst=%h exp pc=%h", i, id_valid, id_pc, id_inst, exp_pc);
            end
            tick();
            if (i == 0) begin
                checks++; if (fq_full !== 1'b0) begin errors++; $display("FAIL fill_full_fall: got %b exp 0", fq_full); end
            end
        end
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b exp 0", id_valid); end
    endtask

    task automatic test_full_enq_deq();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) push(32'h60 + 32'(4 * i), 32'h2000 + 32'(i));
        id_ready = 1'b1;
        push(32'h70, 32'h2070);
        id_ready = 1'b0;
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL simul_count: got %0d exp 4", fq_count); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b exp 0", overflow_err); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h64 + 32'(4 * i);
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin
                errors++; $display("FAIL simul_order[%0d]: got v=%b pc=%h exp %h", i, id_valid, id_pc, exp_pc);
            end
            tick();
        end
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b exp 0", id_valid); end

        for (int i = 0; i < 4; i++) push(32'h60 + 32'(4 * i), 32'h3000 + 32'(i));
        push(32'h70, 32'h3070);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", overflow_err); end
        checks++; if (fq_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", fq_count); end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h60 + 32'(4 * i);
            checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin
                errors++; $display("FAIL ovf_order[%0d]: got v=%b pc=%h exp %h", i, id_valid, id_pc, exp_pc);
            end
            tick();
        end
        id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got v=%b pc=%h exp empty", id_valid, id_pc); end
    endtask

    task automatic test_flush_pending();
        for (int i = 0; i < 3; i++) push(32'h60 + 32'(4 * i), 32'h4000 + 32'(i));
        flush = 1'b1; inst_read = 1'b1;
        tick();
        flush = 1'b0; inst_read = 1'b0;
        checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL flushp_count: got %0d exp 0", fq_count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flushp_valid: got %b exp 0", id_valid); end
        push(32'h74, 32'hDEAD_BEEF);
        checks++; if (id_valid !== 1'b0 || fq_count !== 3'd0) begin
            errors++; $display("FAIL flushp_drop: got v=%b cnt=%0d exp v=0 cnt=0", id_valid, fq_count);
        end
        push(32'h200, 32'h0000_0200);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || fq_count !== 3'd1) begin
            errors++; $display("FAIL flushp_next: got v=%b pc=%h cnt=%0d exp v=1 pc=00000200 cnt=1", id_valid, id_pc, fq_count);
        end
        id_ready = 1'b1; tick(); id_ready = 1'b0;
    endtask

    task automatic test_flush_with_resp();
        push(32'h7C, 32'h7C7C);
        flush = 1'b1;
        push(32'h80, 32'h8080);
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0 || fq_count !== 3'd0) begin
            errors++; $display("FAIL flushr_empty: got v=%b cnt=%0d exp v=0 cnt=0", id_valid, fq_count);
        end
        push(32'h84, 32'h8484);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h84) begin
            errors++; $display("FAIL flushr_pass: got v=%b pc=%h exp v=1 pc=00000084", id_valid, id_pc);
        end
        id_ready = 1'b1; tick(); id_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        // Full queue with sticky overflow still set from earlier: reset must clear all between edges.
        for (int i = 0; i < 4; i++) push(32'h90 + 32'(4 * i), 32'h5000 + 32'(i));
        #2 rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || fq_count !== 3'd0 || fq_full !== 1'b0 || overflow_err !== 1'b0) begin
            errors++; $display("FAIL arst_full: got v=%b cnt=%0d full=%b ovf=%b exp all 0", id_valid, fq_count, fq_full, overflow_err);
        end
        #2 rst = 1'b1;
        tick();
        push(32'hA0, 32'h6000);
        push(32'hA4, 32'h6001);
        flush = 1'b1; inst_read = 1'b1;
        tick();
        flush = 1'b0; inst_read = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || fq_count !== 3'd0 || fq_full !== 1'b0) begin
            errors++; $display("FAIL arst_drop: got v=%b cnt=%0d full=%b exp all 0", id_valid, fq_count, fq_full);
        end
        #2 rst = 1'b1;
        tick();
        push(32'h300, 32'h0000_0300);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_inst !== 32'h300) begin
            errors++; $display("FAIL arst_nodrop: got v=%b pc=%h inst=%h exp v=1 pc=00000300", id_valid, id_pc, id_inst);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_enq_deq();
        test_flush_pending();
        test_flush_with_resp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
